// File: rtl/fft_frame_serializer_if.sv
// Handshake/bus bundle for the FFT frame serializer: a 32-sample frame in,
// one 64-bit complex sample per beat out, plus status.
interface fft_frame_serializer_if;
    logic [2047:0] frame_in;
    logic          frame_valid;
    logic          frame_ready;
    logic [63:0]   s_data;
    logic          s_valid;
    logic          s_ready;
    logic [4:0]    s_index;
    logic          s_last;
    logic          busy;
    logic [15:0]   frame_count;

    // Serializer side
    modport slave (
        input  frame_in, frame_valid, s_ready,
        output frame_ready, s_data, s_valid, s_index, s_last, busy, frame_count
    );

    // Frame source / sample sink side
    modport master (
        output frame_in, frame_valid, s_ready,
        input  frame_ready, s_data, s_valid, s_index, s_last, busy, frame_count
    );
endinterface

// File: rtl/fft_frame_serializer.sv
// Captures a 32-sample complex frame and streams it out one sample per
// handshake, optionally in bit-reversed order and/or conjugated. A new frame
// can be taken on the last-beat handshake so frames stream without a gap.
module fft_frame_serializer #(
    parameter int BITREV = 0,
    parameter int CONJ   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    fft_frame_serializer_if.slave  bus
);
    typedef enum logic {IDLE, STREAM} state_t;

    state_t        state_q, state_d;
    logic [2047:0] buf_q, buf_d;
    logic [4:0]    beat_q, beat_d;
    logic [15:0]   frame_count_q, frame_count_d;

    logic          accept;
    logic          sample_hs;
    logic          last_hs;
    logic [4:0]    sel_idx;
    logic [63:0]   sample;
    logic [63:0]   conj_mask;

    function automatic logic [4:0] rev5(input logic [4:0] b);
        return {b[0], b[1], b[2], b[3], b[4]};
    endfunction

    // Output view of the registered state; s_data is forced to zero outside
    // STREAM so the conjugate mask never leaks onto an idle bus.
    always_comb begin
        sel_idx   = (BITREV != 0) ? rev5(beat_q) : beat_q;
        sample    = buf_q[{sel_idx, 6'd0} +: 64];
        conj_mask = (CONJ != 0) ? 64'h0000_0000_8000_0000 : 64'h0;

        bus.s_valid     = (state_q == STREAM);
        bus.s_data      = bus.s_valid ? (sample ^ conj_mask) : 64'h0;
        bus.s_index     = beat_q;
        bus.s_last      = bus.s_valid && (beat_q == 5'd31);
        bus.busy        = (state_q == STREAM);
        bus.frame_count = frame_count_q;

        sample_hs       = bus.s_valid && bus.s_ready;
        last_hs         = sample_hs && bus.s_last;
        // Ready is combinational from s_ready so a new frame lands on the
        // same edge that retires beat 31.
        bus.frame_ready = (state_q == IDLE) || last_hs;
        accept          = bus.frame_valid && bus.frame_ready;
    end

    // Next-state: beat advance, frame retire, then frame accept overrides.
    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        beat_d        = beat_q;
        frame_count_d = frame_count_q;
        if (sample_hs) begin
            beat_d = beat_q + 5'd1;
        end
        if (last_hs) begin
            frame_count_d = frame_count_q + 16'd1;
            state_d       = IDLE;
        end
        if (accept) begin
            buf_d   = bus.frame_in;
            beat_d  = 5'd0;
            state_d = STREAM;
        end
    end

    // State registers; reset discards any frame in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            buf_q         <= '0;
            beat_q        <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            beat_q        <= beat_d;
            frame_count_q <= frame_count_d;
        end
    end
endmodule

// File: tb/tb_fft_frame_serializer.sv
// Directed bench: a natural-order instance and a bit-reversed conjugating
// instance see identical stimulus and are checked against hand-built frames.
module tb_fft_frame_serializer;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    fft_frame_serializer_if ifn ();
    fft_frame_serializer_if ifr ();

    assign ifr.frame_in    = ifn.frame_in;
    assign ifr.frame_valid = ifn.frame_valid;
    assign ifr.s_ready     = ifn.s_ready;

    fft_frame_serializer #(.BITREV(0), .CONJ(0)) dut_n (.clk(clk), .reset(reset), .bus(ifn.slave));
    fft_frame_serializer #(.BITREV(1), .CONJ(1)) dut_r (.clk(clk), .reset(reset), .bus(ifr.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2047:0] f1, f2, fa, fb;

    function automatic logic [2047:0] mk(input logic [31:0] rbase, input logic [31:0] ibase, input bit istep);
        logic [2047:0] f;
        f = '0;
        for (int j = 0; j < 32; j++)
            f[64*j +: 64] = {rbase + 32'(j), istep ? ibase + 32'(j) : ibase};
        return f;
    endfunction

    function automatic logic [4:0] rev5(input logic [4:0] b);
        return {b[0], b[1], b[2], b[3], b[4]};
    endfunction

    function automatic logic [63:0] smp(input logic [2047:0] f, input int j);
        return f[64*j +: 64];
    endfunction

    function automatic logic [63:0] smp_r(input logic [2047:0] f, input int b);
        return smp(f, int'(rev5(5'(b)))) ^ 64'h0000_0000_8000_0000;
    endfunction

    // Present a frame in an IDLE cycle; returns just after the accepting edge.
    task automatic start_frame(input logic [2047:0] f);
        @(posedge clk); #1;
        ifn.frame_in    = f;
        ifn.frame_valid = 1'b1;
        @(posedge clk); #1;
        ifn.frame_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ifn.frame_in = '0; ifn.frame_valid = 1'b0; ifn.s_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({ifn.s_valid, ifn.s_data, ifn.s_index, ifn.s_last, ifn.busy, ifn.frame_count} !== 88'h0) begin
            n_fail++; $display("FAIL reset_n_outputs got v=%b d=%h i=%0d l=%b b=%b c=%0d want all 0",
                ifn.s_valid, ifn.s_data, ifn.s_index, ifn.s_last, ifn.busy, ifn.frame_count);
        end
        n_checks++;
        if ({ifr.s_valid, ifr.s_data, ifr.s_index, ifr.s_last, ifr.busy, ifr.frame_count} !== 88'h0) begin
            n_fail++; $display("FAIL reset_r_outputs got v=%b d=%h c=%0d want all 0", ifr.s_valid, ifr.s_data, ifr.frame_count);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ifn.frame_ready !== 1'b1 || ifr.frame_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready got %b/%b want 1/1", ifn.frame_ready, ifr.frame_ready);
        end
    endtask

    task automatic test_idle_ignore();
        ifn.frame_valid = 1'b0;
        ifn.frame_in    = f2;
        ifn.s_ready     = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if ({ifn.s_valid, ifn.busy, ifn.frame_ready, ifr.s_valid, ifr.busy, ifr.frame_ready} !== 6'b001001) begin
                n_fail++; $display("FAIL idle_ignore cycle %0d got v=%b b=%b r=%b want v=0 b=0 r=1", c, ifn.s_valid, ifn.busy, ifn.frame_ready);
            end
        end
    endtask

    task automatic test_natural_and_bitrev();
        ifn.s_ready = 1'b1;
        start_frame(f1);
        ifn.frame_in = {64{32'hdead_beef}};
        for (int b = 0; b < 32; b++) begin
            @(negedge clk);
            n_checks++;
            if (ifn.s_valid !== 1'b1 || ifn.s_data !== smp(f1, b) || ifn.s_index !== 5'(b) || ifn.s_last !== (b == 31)) begin
                n_fail++; $display("FAIL natural beat %0d got v=%b d=%h i=%0d l=%b want v=1 d=%h i=%0d l=%b",
                    b, ifn.s_valid, ifn.s_data, ifn.s_index, ifn.s_last, smp(f1, b), b, (b == 31));
            end
            n_checks++;
            if (ifr.s_data !== smp_r(f1, b) || ifr.s_data[31:0] !== 32'h8000_0000) begin
                n_fail++; $display("FAIL bitrev_conj beat %0d got %h want %h", b, ifr.s_data, smp_r(f1, b));
            end
            if (b == 1 || b == 2 || b == 31) begin
                n_checks++;
                if (ifr.s_data[63:32] !== ((b == 1) ? 32'h3f80_0010 : (b == 2) ? 32'h3f80_0008 : 32'h3f80_001f)) begin
                    n_fail++; $display("FAIL bitrev_spot beat %0d got real %h", b, ifr.s_data[63:32]);
                end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++;
        if (ifn.s_valid !== 1'b0 || ifn.busy !== 1'b0 || ifn.frame_count !== 16'd1 || ifr.frame_count !== 16'd1) begin
            n_fail++; $display("FAIL natural_end got v=%b b=%b cnt=%0d/%0d want v=0 b=0 cnt=1/1",
                ifn.s_valid, ifn.busy, ifn.frame_count, ifr.frame_count);
        end
    endtask

    task automatic test_backpressure();
        int exp_beat;
        int cyc;
        exp_beat = 0;
        cyc = 0;
        start_frame(f2);
        ifn.frame_in = '1;
        while (exp_beat < 32 && cyc < 200) begin
            ifn.s_ready = (cyc % 3 == 0);
            @(negedge clk);
            n_checks++;
            if (ifn.s_valid !== 1'b1 || ifn.s_data !== smp(f2, exp_beat) || ifn.s_index !== 5'(exp_beat) ||
                ifr.s_data !== smp_r(f2, exp_beat) || ifn.s_last !== (exp_beat == 31)) begin
                n_fail++; $display("FAIL backpressure cycle %0d got i=%0d d=%h r=%h want i=%0d d=%h r=%h",
                    cyc, ifn.s_index, ifn.s_data, ifr.s_data, exp_beat, smp(f2, exp_beat), smp_r(f2, exp_beat));
            end
            if (ifn.s_ready) exp_beat++;
            @(posedge clk); #1;
            cyc++;
        end
        ifn.s_ready = 1'b1;
        n_checks++;
        if (exp_beat !== 32) begin
            n_fail++; $display("FAIL backpressure_beats got %0d want 32 within budget", exp_beat);
        end
        @(negedge clk);
        n_checks++;
        if (ifn.s_valid !== 1'b0 || ifn.frame_count !== 16'd2) begin
            n_fail++; $display("FAIL backpressure_end got v=%b cnt=%0d want v=0 cnt=2", ifn.s_valid, ifn.frame_count);
        end
    endtask

    task automatic test_back_to_back();
        ifn.s_ready = 1'b1;
        @(posedge clk); #1;
        ifn.frame_in    = fa;
        ifn.frame_valid = 1'b1;
        @(posedge clk); #1;
        ifn.frame_in    = fb;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            n_checks++;
            if (ifn.s_valid !== 1'b1 || ifn.s_index !== 5'(k % 32) ||
                ifn.s_data !== ((k < 32) ? smp(fa, k) : smp(fb, k - 32)) ||
                ifr.s_data !== ((k < 32) ? smp_r(fa, k) : smp_r(fb, k - 32))) begin
                n_fail++; $display("FAIL b2b beat %0d got v=%b i=%0d d=%h", k, ifn.s_valid, ifn.s_index, ifn.s_data);
            end
            n_checks++;
            if (ifn.frame_ready !== ((k % 32) == 31)) begin
                n_fail++; $display("FAIL b2b_ready beat %0d got %b want %b", k, ifn.frame_ready, ((k % 32) == 31));
            end
            if (k == 32) begin
                n_checks++;
                if (ifn.frame_count !== 16'd3) begin
                    n_fail++; $display("FAIL b2b_count_mid got %0d want 3", ifn.frame_count);
                end
            end
            @(posedge clk); #1;
            if (k == 31) ifn.frame_valid = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (ifn.s_valid !== 1'b0 || ifn.frame_count !== 16'd4 || ifr.frame_count !== 16'd4) begin
            n_fail++; $display("FAIL b2b_end got v=%b cnt=%0d want v=0 cnt=4", ifn.s_valid, ifn.frame_count);
        end
    endtask

    task automatic test_reset_midstream();
        ifn.s_ready = 1'b1;
        start_frame(f1);
        for (int b = 0; b < 10; b++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++;
        if (ifn.s_index !== 5'd10 || ifn.s_valid !== 1'b1) begin
            n_fail++; $display("FAIL midstream_pre got i=%0d v=%b want i=10 v=1", ifn.s_index, ifn.s_valid);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({ifn.s_valid, ifn.busy, ifn.frame_count, ifn.s_index, ifn.s_data} !== 87'h0 ||
            {ifr.s_valid, ifr.frame_count, ifr.s_data} !== 81'h0) begin
            n_fail++; $display("FAIL midstream_async got v=%b b=%b cnt=%0d i=%0d d=%h rd=%h want all 0",
                ifn.s_valid, ifn.busy, ifn.frame_count, ifn.s_index, ifn.s_data, ifr.s_data);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ifn.frame_ready !== 1'b1 || ifn.s_valid !== 1'b0) begin
            n_fail++; $display("FAIL midstream_release got r=%b v=%b want r=1 v=0", ifn.frame_ready, ifn.s_valid);
        end
        start_frame(f2);
        for (int b = 0; b < 32; b++) begin
            @(negedge clk);
            n_checks++;
            if (ifn.s_index !== 5'(b) || ifn.s_data !== smp(f2, b) || ifr.s_data !== smp_r(f2, b)) begin
                n_fail++; $display("FAIL post_reset beat %0d got i=%0d d=%h want d=%h", b, ifn.s_index, ifn.s_data, smp(f2, b));
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++;
        if (ifn.frame_count !== 16'd1 || ifn.s_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_end got cnt=%0d v=%b want cnt=1 v=0", ifn.frame_count, ifn.s_valid);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        f1 = mk(32'h3f80_0000, 32'h0, 1'b0);
        f2 = mk(32'h4000_0000, 32'h0000_1000, 1'b1);
        fa = mk(32'h4100_0000, 32'hc000_0000, 1'b1);
        fb = mk(32'h4200_0100, 32'h0123_0000, 1'b1);
        test_reset();
        test_idle_ignore();
        test_natural_and_bitrev();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fft_frame_serializer.md
FFT_FRAME_SERIALIZER -- requirements
Module: fft_frame_serializer

Interface
REQ-001 The block SHALL have exactly one clock and SHALL have an asynchronous, active-high reset.
REQ-002 Parameter: BITREV, 0, 1 = emit samples in bit-reversed index order, 0 = natural order.
REQ-003 Parameter: CONJ, 0, 1 = invert bit 31 (imaginary sign) of every emitted sample.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 frame_in  input  2048  32 complex samples; sample j = frame_in[64j+63:64j], bits [63:32] real float32, [31:0] imag float32.
REQ-007 frame_valid  input  1  frame_in is valid.
REQ-008 frame_ready  output  1  the block accepts frame_in this cycle.
REQ-009 s_data  output  64  current output sample.
REQ-010 s_valid  output  1  s_data, s_index and s_last are valid.
REQ-011 s_ready  input  1  the downstream sink accepts the sample.
REQ-012 s_index  output  5  beat number of the current sample, 0..31.
REQ-013 s_last  output  1  high when s_index = 31 and s_valid = 1.
REQ-014 busy  output  1  high in STREAM state.
REQ-015 frame_count  output  16  number of fully emitted frames, wraps modulo 2^16.

Function
REQ-016 FSM states:
- IDLE: s_valid = 0, frame_ready = 1.
- STREAM: s_valid = 1.
REQ-017 Frame accept is frame_valid && frame_ready at a rising edge. On accept, the block SHALL copy frame_in into an internal 2048-bit buffer, set beat to 0 and enter STREAM.
REQ-018 Latency: s_valid SHALL rise on the edge that accepts the frame, and s_data SHALL carry beat 0 in the same cycle, with no further delay.
REQ-019 Beat b selects buffer sample j, where j = b when BITREV = 0, and j = bit-reverse(b) over 5 bits when BITREV = 1.
REQ-020 s_data SHALL equal the selected sample, with bit 31 inverted when CONJ = 1.
REQ-021 A sample handshake is s_valid && s_ready at a rising edge; each handshake SHALL advance beat by 1.
REQ-022 While s_valid = 1 and s_ready = 0, s_data, s_index and s_last SHALL hold stable.
REQ-023 The buffer SHALL NOT change while in STREAM except by the back-to-back accept in REQ-025.
REQ-024 frame_ready SHALL be (state == IDLE) || (s_valid && s_ready && s_last). It is combinational from s_ready.
REQ-025 Back-to-back: on the handshake where s_last = 1, with frame_valid = 1:
- the new frame SHALL be captured;
- beat SHALL wrap to 0;
- the state SHALL remain STREAM, with no idle cycle between frames.
REQ-026 On the handshake where s_last = 1, with frame_valid = 0: the state SHALL return to IDLE and s_valid SHALL drop on that edge.
REQ-027 frame_count SHALL increment by 1 on every handshake where s_last = 1, whether or not a new frame is accepted on the same edge.
REQ-028 frame_valid SHALL be ignored in STREAM except on the last-beat handshake.
REQ-029 frame_in SHALL NOT be sampled while frame_ready = 0.

Reset
REQ-030 On reset assertion, the block SHALL immediately enter IDLE and clear the following, regardless of clk:
- s_valid = 0, s_data = 0, s_index = 0, s_last = 0;
- busy = 0, frame_count = 0;
- buffer = 0.
REQ-031 Reset during STREAM SHALL discard the frame in progress; no further beats of that frame SHALL be emitted.
REQ-032 After reset deassertion, frame_ready SHALL be 1 in the first cycle.

Verification
REQ-033 Natural order: BITREV = 0, CONJ = 0, sample j = {32'h3f800000 + j, 32'h0}, s_ready held at 1 -> 32 beats in 32 consecutive cycles; beat b carries real field 3f800000+b; s_last high only on beat 31; frame_count = 1; then IDLE.
REQ-034 Bit-reversed conjugate order: BITREV = 1, CONJ = 1, same frame -> beat 1 carries sample 16, beat 2 sample 8, beat 31 sample 31; each imag field = 32'h80000000.
REQ-035 Backpressure: s_ready toggling 1,0,0,1,... -> s_data stable through every stall; no beat is lost or duplicated; total beats = 32.
REQ-036 Back-to-back: frame_valid held high with two distinct frames -> frame_ready = 1 exactly on the beat-31 handshake; beat 0 of frame 2 appears on the next cycle, with no gap; frame_count = 2.
REQ-037 Reset mid-stream: reset asserted asynchronously at beat 10 -> s_valid = 0 and frame_count = 0 before the next clk edge; a new frame after release starts at beat 0.
REQ-038 Idle ignore: frame_valid = 0 for 20 cycles -> s_valid stays 0, busy = 0, frame_ready = 1.
